cache_fill_arbiter: RTL and testbench

- Miss-service engine between the I-cache/D-cache arrays and the shared multicycle main memory; sits directly upstream of the pipeline's IF and MEM stages.
- Arbitrates I-cache miss, D-cache miss and write-through store requests onto the single memory port.
- Fills a 16-byte (8-word) block word by word, then writes the tag.
- Raises the stall signals that freeze the PC and the pipeline registers.

---
 rtl/cache_fill_arbiter.sv | 172 +++++++++++++++++
 tb/tb_cache_fill_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter
//   Miss-service engine between the I/D cache arrays and the shared main
//   memory port. Serves D-cache misses, store write-throughs and I-cache
//   misses (that priority order) one at a time. A miss fills a whole 8-word
//   block with pipelined reads, then pulses the owner's tag write. A store
//   that missed completes with a write-through right after its fill.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   I_miss, I_addr           I-cache miss request (held until tag written)
//   D_miss, D_addr           D-cache miss request (held until tag written)
//   D_write, D_wdata         store in the MEM stage and its data
//   mem_data_in/_valid       memory read return
//   mem_enable, mem_wr,
//   mem_addr, mem_data_out   memory command port
//   fill_data, fill_word     word and offset being written into a data array
//   I_/D_data_we             data-array write enables
//   I_/D_tag_we              one-cycle tag/valid write pulses
//   I_stall, D_stall         freeze fetch / freeze all pipeline registers
module cache_fill_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int WORDS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        I_miss,
  input  logic [15:0] I_addr,
  input  logic        D_miss,
  input  logic [15:0] D_addr,
  input  logic        D_write,
  input  logic [15:0] D_wdata,
  input  logic [15:0] mem_data_in,
  input  logic        mem_data_valid,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_out,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        I_data_we,
  output logic        D_data_we,
  output logic        I_tag_we,
  output logic        D_tag_we,
  output logic        I_stall,
  output logic        D_stall
);

  // The block geometry (3-bit word offset) and a pipelined memory with at
  // least one cycle of latency are baked into the datapath below.
  if (MEM_LAT < 1 || WORDS != 8) begin : g_cfg_check
    $error("cache_fill_arbiter: unsupported MEM_LAT/WORDS configuration");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t      state;
  logic        owner_d;     // 1: current fill belongs to the D-cache
  logic [3:0]  issue_cnt;   // reads issued for the current block
  logic [3:0]  recv_cnt;    // read returns consumed for the current block
  logic [11:0] base;        // block base address[15:4]

  logic in_fill;
  logic issue_ok;
  logic recv_ok;
  logic last_word;

  // Only the block base of the fetch address matters.
  logic unused_i_addr_lsbs;
  assign unused_i_addr_lsbs = ^I_addr[3:0];

  assign in_fill   = (state == FILL);
  assign issue_ok  = in_fill && (issue_cnt < 4'(WORDS));
  // Returns outside FILL (including stragglers from before a reset) are dropped.
  assign recv_ok   = in_fill && mem_data_valid;
  assign last_word = (recv_cnt == 4'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          issue_cnt <= '0;
          recv_cnt  <= '0;
          if (D_miss) begin
            state   <= FILL;
            owner_d <= 1'b1;
            base    <= D_addr[15:4];
          end else if (D_write) begin
            state   <= WRITE;
          end else if (I_miss) begin
            state   <= FILL;
            owner_d <= 1'b0;
            base    <= I_addr[15:4];
          end
        end
        FILL: begin
          if (issue_ok) begin
            issue_cnt <= issue_cnt + 4'd1;
          end
          if (recv_ok) begin
            if (last_word) begin
              issue_cnt <= '0;
              recv_cnt  <= '0;
              // Write-allocate: a store that missed finishes after its fill.
              state     <= (owner_d && D_write) ? WRITE : IDLE;
            end else begin
              recv_cnt  <= recv_cnt + 4'd1;
            end
          end
        end
        WRITE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode the registered state in the same cycle: the read
  // command must leave on the first FILL cycle and the returned word must
  // reach the array in the cycle it is valid. Everything is held at 0
  // while rst is asserted.
  always_comb begin
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_out = '0;
    fill_data    = '0;
    fill_word    = '0;
    I_data_we    = 1'b0;
    D_data_we    = 1'b0;
    I_tag_we     = 1'b0;
    D_tag_we     = 1'b0;
    I_stall      = 1'b0;
    D_stall      = 1'b0;
    if (!rst) begin
      if (issue_ok) begin
        mem_enable = 1'b1;
        mem_addr   = {base, issue_cnt[2:0], 1'b0};
      end else if (state == WRITE) begin
        mem_enable   = 1'b1;
        mem_wr       = 1'b1;
        mem_addr     = D_addr;
        mem_data_out = D_wdata;
      end
      if (recv_ok) begin
        fill_data = mem_data_in;
        fill_word = recv_cnt[2:0];
        I_data_we = ~owner_d;
        D_data_we = owner_d;
        if (last_word) begin
          I_tag_we = ~owner_d;
          D_tag_we = owner_d;
        end
      end
      I_stall = I_miss | (state != IDLE);
      // The store's commit cycle (WRITE) releases the pipeline.
      D_stall = D_miss | (D_write & (state != WRITE));
    end
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
module tb_cache_fill_arbiter;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        I_miss;
  logic [15:0] I_addr;
  logic        D_miss;
  logic [15:0] D_addr;
  logic        D_write;
  logic [15:0] D_wdata;
  logic [15:0] mem_data_in;
  logic        mem_data_valid;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_out;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        I_data_we;
  logic        D_data_we;
  logic        I_tag_we;
  logic        D_tag_we;
  logic        I_stall;
  logic        D_stall;

  cache_fill_arbiter #(.MEM_LAT(L), .WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .I_miss(I_miss), .I_addr(I_addr),
    .D_miss(D_miss), .D_addr(D_addr),
    .D_write(D_write), .D_wdata(D_wdata),
    .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_out(mem_data_out), .fill_data(fill_data), .fill_word(fill_word),
    .I_data_we(I_data_we), .D_data_we(D_data_we),
    .I_tag_we(I_tag_we), .D_tag_we(D_tag_we),
    .I_stall(I_stall), .D_stall(D_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_out;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        I_data_we;
    logic        D_data_we;
    logic        I_tag_we;
    logic        D_tag_we;
    logic        I_stall;
    logic        D_stall;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic        im;
    logic [15:0] ia;
    logic        dm;
    logic [15:0] da;
    logic        dw;
    logic [15:0] wd;
    logic        xv;   // stray valid when no read is due
    logic [15:0] xd;
  } drv_t;

  // One episode: a set of requests raised together at t=0.
  typedef struct packed {
    logic        i;
    logic        d;
    logic        w;
    logic [15:0] ia;
    logic [15:0] da;
    logic [15:0] wd;
  } ep_t;

  typedef struct {
    int          due;
    logic [15:0] addr;
  } rd_t;

  typedef struct {
    logic        im, dm, dw, v;
    logic [15:0] md;
    logic        exp_is, exp_ds;
  } vec_t;

  rd_t rq[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_fail = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'd40503;
    return p ^ 16'h3C3C;
  endfunction

  // Timeline of an episode: optional D fill (t=1..8+L) followed by the
  // store commit, or a lone store commit at t=1; the I fill starts from the
  // first idle cycle s_i after that.
  function automatic void ep_times(input ep_t e, output int write_t,
                                   output int s_i, output int end_t);
    write_t = -1;
    s_i     = 0;
    if (e.d) begin
      write_t = e.w ? 9 + L : -1;
      s_i     = e.w ? 10 + L : 9 + L;
    end else if (e.w) begin
      write_t = 1;
      s_i     = 2;
    end
    end_t = e.i ? s_i + 9 + L : s_i;
  endfunction

  function automatic drv_t drv_at(input ep_t e, input int t);
    drv_t d;
    int wt, si, et;
    ep_times(e, wt, si, et);
    d    = '0;
    d.ia = e.ia;
    d.da = e.da;
    d.wd = e.wd;
    d.im = e.i && (t <= si + 8 + L);
    d.dm = e.d && (t <= 8 + L);
    d.dw = e.w && (t <= wt);
    return d;
  endfunction

  function automatic out_t exp_at(input ep_t e, input int t);
    out_t x;
    drv_t d;
    int wt, si, et, k;
    logic busy;
    ep_times(e, wt, si, et);
    d = drv_at(e, t);
    x = '0;
    if (e.d && t >= 1 && t <= 8) begin
      x.mem_enable = 1'b1;
      x.mem_addr   = {e.da[15:4], 3'(t - 1), 1'b0};
    end
    if (e.i && t >= si + 1 && t <= si + 8) begin
      x.mem_enable = 1'b1;
      x.mem_addr   = {e.ia[15:4], 3'(t - si - 1), 1'b0};
    end
    if (t == wt) begin
      x.mem_enable   = 1'b1;
      x.mem_wr       = 1'b1;
      x.mem_addr     = e.da;
      x.mem_data_out = e.wd;
    end
    if (e.d && t >= 1 + L && t <= 8 + L) begin
      k = t - 1 - L;
      x.fill_word = 3'(k);
      x.fill_data = mem_word({e.da[15:4], 3'(k), 1'b0});
      x.D_data_we = 1'b1;
      x.D_tag_we  = (k == 7);
    end
    if (e.i && t >= si + 1 + L && t <= si + 8 + L) begin
      k = t - si - 1 - L;
      x.fill_word = 3'(k);
      x.fill_data = mem_word({e.ia[15:4], 3'(k), 1'b0});
      x.I_data_we = 1'b1;
      x.I_tag_we  = (k == 7);
    end
    busy = (e.d && t >= 1 && t <= 8 + L) || (t == wt) ||
           (e.i && t >= si + 1 && t <= si + 8 + L);
    x.I_stall = d.im | busy;
    x.D_stall = d.dm | (d.dw & (t != wt));
    return x;
  endfunction

  function automatic out_t actual();
    out_t a;
    a.mem_enable   = mem_enable;
    a.mem_wr       = mem_wr;
    a.mem_addr     = mem_addr;
    a.mem_data_out = mem_data_out;
    a.fill_data    = fill_data;
    a.fill_word    = fill_word;
    a.I_data_we    = I_data_we;
    a.D_data_we    = D_data_we;
    a.I_tag_we     = I_tag_we;
    a.D_tag_we     = D_tag_we;
    a.I_stall      = I_stall;
    a.D_stall      = D_stall;
    return a;
  endfunction

  task automatic check(input out_t x, input string name);
    out_t a;
    a = actual();
    n_cmp++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, a, x);
    end
  endtask

  // One clock cycle: drive inputs plus the memory return due now, compare
  // mid-cycle, record any read the DUT issues, then advance.
  task automatic do_cycle(input drv_t d, input out_t x, input string name);
    rst     = d.rst;
    I_miss  = d.im;
    I_addr  = d.ia;
    D_miss  = d.dm;
    D_addr  = d.da;
    D_write = d.dw;
    D_wdata = d.wd;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      mem_data_valid = 1'b1;
      mem_data_in    = mem_word(rq[0].addr);
      void'(rq.pop_front());
    end else begin
      mem_data_valid = d.xv;
      mem_data_in    = d.xd;
    end
    #4;
    check(x, name);
    if (mem_enable === 1'b1 && mem_wr === 1'b0) begin
      rq.push_back('{due: cyc + L, addr: mem_addr});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_ep(input ep_t e, input string name);
    int wt, si, et;
    ep_times(e, wt, si, et);
    for (int t = 0; t <= et; t++) begin
      do_cycle(drv_at(e, t), exp_at(e, t), name);
    end
  endtask

  task automatic idle_gap(input int n, input string name);
    drv_t d;
    for (int g = 0; g < n; g++) begin
      d    = '0;
      d.xv = 1'($urandom_range(0, 1));
      d.xd = 16'($urandom);
      d.ia = 16'($urandom);
      d.da = 16'($urandom);
      do_cycle(d, '0, name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d time limit reached", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    ep_t  e;
    drv_t d;
    out_t x;

    rst = 1'b1; I_miss = 0; I_addr = 0; D_miss = 0; D_addr = 0;
    D_write = 0; D_wdata = 0; mem_data_in = 0; mem_data_valid = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset holds every output at 0 even with all requests raised.
    d = '0; d.rst = 1; d.im = 1; d.dm = 1; d.dw = 1; d.xv = 1;
    d.ia = 16'h1234; d.da = 16'h5678; d.wd = 16'h9ABC; d.xd = 16'hFFFF;
    do_cycle(d, '0, "reset_outputs");
    do_cycle('0, '0, "after_reset_idle");

    // Combinational stall decode in IDLE; requests withdrawn before the edge.
    vecs[0] = '{im: 0, dm: 0, dw: 0, v: 1, md: 16'hAAAA, exp_is: 0, exp_ds: 0};
    vecs[1] = '{im: 1, dm: 0, dw: 0, v: 0, md: 16'h0000, exp_is: 1, exp_ds: 0};
    vecs[2] = '{im: 0, dm: 1, dw: 0, v: 0, md: 16'h0000, exp_is: 0, exp_ds: 1};
    vecs[3] = '{im: 0, dm: 0, dw: 1, v: 0, md: 16'h0000, exp_is: 0, exp_ds: 1};
    vecs[4] = '{im: 1, dm: 1, dw: 0, v: 1, md: 16'h5555, exp_is: 1, exp_ds: 1};
    vecs[5] = '{im: 0, dm: 0, dw: 1, v: 1, md: 16'h1357, exp_is: 0, exp_ds: 1};
    for (int i = 0; i < 6; i++) begin
      I_miss = vecs[i].im; D_miss = vecs[i].dm; D_write = vecs[i].dw;
      mem_data_valid = vecs[i].v; mem_data_in = vecs[i].md;
      I_addr = 16'h0100; D_addr = 16'h0200; D_wdata = 16'h0300;
      #1;
      x = '0;
      x.I_stall = vecs[i].exp_is;
      x.D_stall = vecs[i].exp_ds;
      check(x, $sformatf("idle_vec%0d", i));
    end
    I_miss = 0; D_miss = 0; D_write = 0; mem_data_valid = 0;
    @(posedge clk);
    #1;
    cyc++;

    // I-cache miss fill of block 0x0020.
    e = '0; e.i = 1; e.ia = 16'h0024;
    run_ep(e, "i_fill");
    idle_gap(2, "gap");

    // D and I miss together: D first, then I.
    e = '0; e.i = 1; e.ia = 16'h0040; e.d = 1; e.da = 16'h1008;
    run_ep(e, "d_then_i");
    idle_gap(2, "gap");

    // Store hit.
    e = '0; e.w = 1; e.da = 16'h2006; e.wd = 16'hBEEF;
    run_ep(e, "store_hit");
    idle_gap(2, "gap");

    // Store miss: fill then write-through.
    e = '0; e.d = 1; e.w = 1; e.da = 16'h3010; e.wd = 16'h1234;
    run_ep(e, "store_miss");
    idle_gap(2, "gap");

    // Reset in the middle of an I fill.
    e = '0; e.i = 1; e.ia = 16'h0024;
    for (int t = 0; t <= 5; t++) begin
      do_cycle(drv_at(e, t), exp_at(e, t), "rst_mid_fill_pre");
    end
    d = '0; d.rst = 1; d.ia = 16'h0024;
    do_cycle(d, '0, "rst_mid_fill_rst");
    for (int t = 7; t <= 10; t++) begin
      d = '0; d.ia = 16'h0024;
      do_cycle(d, '0, "rst_mid_fill_stale");
    end
    run_ep(e, "rst_refill");

    // Stray valids while idle.
    idle_gap(6, "stray_valid");

    // Random request mixes.
    for (int n = 0; n < 40; n++) begin
      e    = '0;
      e.i  = 1'($urandom_range(0, 1));
      e.d  = 1'($urandom_range(0, 1));
      e.w  = 1'($urandom_range(0, 1));
      e.ia = 16'($urandom);
      e.da = 16'($urandom);
      e.wd = 16'($urandom);
      run_ep(e, $sformatf("rand%0d", n));
      idle_gap(int'($urandom_range(1, 3)), "rand_gap");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
